// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
// Module      : control_unit
// Description : Multi-cycle instruction sequencer (fetch T0-T2, execute T3-T7)
//               with registered control outputs and stop/halt handling.
// Revision    : 1.0
// ============================================================================
module control_unit (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] IR,
  input  logic        CON,
  input  logic        stop,
  output logic        run,
  output logic        PCout, Zlowout, Zhighout, MDRout, Cout, In_Portout, LOout, HIout,
  output logic        MARIn, ZIn, PCIn, MDRIn, IRIn, YIn, IncPC, HiIn, LoIn, CIn, InIn, OutIn,
  output logic        Gra, Grb, Grc, Rin, Rout, BAout,
  output logic        read, write,
  output logic [4:0]  alu_op
);

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  localparam logic [4:0] c_OP_LD   = 5'b00000;
  localparam logic [4:0] c_OP_LDI  = 5'b00001;
  localparam logic [4:0] c_OP_ST   = 5'b00010;
  localparam logic [4:0] c_OP_ADD  = 5'b00011;
  localparam logic [4:0] c_OP_SUB  = 5'b00100;
  localparam logic [4:0] c_OP_AND  = 5'b00101;
  localparam logic [4:0] c_OP_OR   = 5'b00110;
  localparam logic [4:0] c_OP_ADDI = 5'b01100;
  localparam logic [4:0] c_OP_BR   = 5'b10011;
  localparam logic [4:0] c_OP_IN   = 5'b10101;
  localparam logic [4:0] c_OP_OUT  = 5'b10110;
  localparam logic [4:0] c_OP_MFHI = 5'b10111;
  localparam logic [4:0] c_OP_MFLO = 5'b11000;
  localparam logic [4:0] c_OP_HALT = 5'b11010;

  typedef struct packed {
    logic       run;
    logic [4:0] alu_op;
    logic PCout, Zlowout, Zhighout, MDRout, Cout, In_Portout, LOout, HIout;
    logic MARIn, ZIn, PCIn, MDRIn, IRIn, YIn, IncPC, HiIn, LoIn, CIn, InIn, OutIn;
    logic Gra, Grb, Grc, Rin, Rout, BAout;
    logic read, write;
  } ctrl_t;

  state_t     r_state;
  logic [4:0] r_opcode;
  logic       r_con;
  ctrl_t      r_ctrl;

  state_t     w_state_nxt;
  logic [4:0] w_op_nxt;
  logic       w_con_nxt;
  logic       w_unused_ir;

  function automatic logic f_is_alu(input logic [4:0] op);
    return (op == c_OP_ADD) || (op == c_OP_SUB) || (op == c_OP_AND) || (op == c_OP_OR);
  endfunction

  function automatic logic f_is_imm(input logic [4:0] op);
    return (op == c_OP_ADDI) || (op == c_OP_LDI);
  endfunction

  function automatic logic f_is_mem(input logic [4:0] op);
    return (op == c_OP_LD) || (op == c_OP_ST);
  endfunction

  // Every opcode that is not a multi-step instruction (including undefined ones) ends at T3.
  function automatic logic f_ends_t3(input logic [4:0] op);
    return !(f_is_alu(op) || f_is_imm(op) || f_is_mem(op) || (op == c_OP_BR));
  endfunction

  function automatic state_t f_next(input state_t s, input logic [4:0] op,
                                    input logic [4:0] ir_op, input logic stp);
    state_t last;
    last = stp ? S_HALT : S_T0;
    case (s)
      S_RESET: f_next = S_T0;
      S_T0:    f_next = S_T1;
      S_T1:    f_next = S_T2;
      S_T2:    f_next = (ir_op == c_OP_HALT) ? S_HALT : S_T3;
      S_T3:    f_next = f_ends_t3(op) ? last : S_T4;
      S_T4:    f_next = S_T5;
      S_T5:    f_next = (f_is_alu(op) || f_is_imm(op)) ? last : S_T6;
      S_T6:    f_next = (op == c_OP_BR) ? last : S_T7;
      S_T7:    f_next = last;
      S_HALT:  f_next = S_HALT;
      default: f_next = S_RESET;
    endcase
  endfunction

  function automatic ctrl_t f_ctrl(input state_t s, input logic [4:0] op, input logic con);
    ctrl_t c;
    c     = '0;
    c.run = (s != S_RESET) && (s != S_HALT);
    case (s)
      S_T0: begin c.PCout = 1'b1; c.MARIn = 1'b1; c.IncPC = 1'b1; c.ZIn = 1'b1; end
      S_T1: begin c.Zlowout = 1'b1; c.PCIn = 1'b1; c.read = 1'b1; c.MDRIn = 1'b1; end
      S_T2: begin c.MDRout = 1'b1; c.IRIn = 1'b1; end
      S_T3: begin
        case (op)
          c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_OR, c_OP_ADDI:
                     begin c.Grb = 1'b1; c.Rout = 1'b1; c.YIn = 1'b1; end
          c_OP_LDI, c_OP_LD, c_OP_ST:
                     begin c.Grb = 1'b1; c.BAout = 1'b1; c.YIn = 1'b1; end
          c_OP_BR:   begin c.Gra = 1'b1; c.Rout = 1'b1; end
          c_OP_IN:   begin c.In_Portout = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1; end
          c_OP_OUT:  begin c.Gra = 1'b1; c.Rout = 1'b1; c.OutIn = 1'b1; end
          c_OP_MFHI: begin c.HIout = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1; end
          c_OP_MFLO: begin c.LOout = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1; end
          default: ;
        endcase
      end
      S_T4: begin
        if (f_is_alu(op)) begin
          c.Grc = 1'b1; c.Rout = 1'b1; c.ZIn = 1'b1; c.alu_op = op;
        end else if (f_is_imm(op) || f_is_mem(op)) begin
          c.Cout = 1'b1; c.ZIn = 1'b1; c.alu_op = c_OP_ADD;
        end else if (op == c_OP_BR) begin
          c.PCout = 1'b1; c.YIn = 1'b1;
        end
      end
      S_T5: begin
        if (f_is_alu(op) || f_is_imm(op)) begin
          c.Zlowout = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1;
        end else if (f_is_mem(op)) begin
          c.Zlowout = 1'b1; c.MARIn = 1'b1;
        end else if (op == c_OP_BR) begin
          c.Cout = 1'b1; c.ZIn = 1'b1; c.alu_op = c_OP_ADD;
        end
      end
      S_T6: begin
        if (op == c_OP_LD) begin
          c.read = 1'b1; c.MDRIn = 1'b1;
        end else if (op == c_OP_ST) begin
          c.Gra = 1'b1; c.Rout = 1'b1; c.MDRIn = 1'b1;
        end else if ((op == c_OP_BR) && con) begin
          c.Zlowout = 1'b1; c.PCIn = 1'b1;
        end
      end
      S_T7: begin
        if (op == c_OP_LD) begin
          c.MDRout = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1;
        end else if (op == c_OP_ST) begin
          c.write = 1'b1;
        end
      end
      default: ;
    endcase
    return c;
  endfunction

  // Outputs are registered from the next state so they line up with r_state.
  assign w_op_nxt    = (r_state == S_T2) ? IR[31:27] : r_opcode;
  assign w_con_nxt   = (r_state == S_T3) ? CON : r_con;
  assign w_state_nxt = f_next(r_state, r_opcode, IR[31:27], stop);
  assign w_unused_ir = ^IR[26:0];

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state  <= S_RESET;
      r_opcode <= 5'b00000;
      r_con    <= 1'b0;
      r_ctrl   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_opcode <= w_op_nxt;
      r_con    <= w_con_nxt;
      r_ctrl   <= f_ctrl(w_state_nxt, w_op_nxt, w_con_nxt);
    end
  end

  assign run        = r_ctrl.run;
  assign alu_op     = r_ctrl.alu_op;
  assign PCout      = r_ctrl.PCout;
  assign Zlowout    = r_ctrl.Zlowout;
  assign Zhighout   = r_ctrl.Zhighout;
  assign MDRout     = r_ctrl.MDRout;
  assign Cout       = r_ctrl.Cout;
  assign In_Portout = r_ctrl.In_Portout;
  assign LOout      = r_ctrl.LOout;
  assign HIout      = r_ctrl.HIout;
  assign MARIn      = r_ctrl.MARIn;
  assign ZIn        = r_ctrl.ZIn;
  assign PCIn       = r_ctrl.PCIn;
  assign MDRIn      = r_ctrl.MDRIn;
  assign IRIn       = r_ctrl.IRIn;
  assign YIn        = r_ctrl.YIn;
  assign IncPC      = r_ctrl.IncPC;
  assign HiIn       = r_ctrl.HiIn;
  assign LoIn       = r_ctrl.LoIn;
  assign CIn        = r_ctrl.CIn;
  assign InIn       = r_ctrl.InIn;
  assign OutIn      = r_ctrl.OutIn;
  assign Gra        = r_ctrl.Gra;
  assign Grb        = r_ctrl.Grb;
  assign Grc        = r_ctrl.Grc;
  assign Rin        = r_ctrl.Rin;
  assign Rout       = r_ctrl.Rout;
  assign BAout      = r_ctrl.BAout;
  assign read       = r_ctrl.read;
  assign write      = r_ctrl.write;

endmodule
`default_nettype wire
